// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 opcode, immediate-width and fetch-state constants
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [3:0] W_NONE = 4'd0;
  localparam logic [3:0] W5     = 4'd5;
  localparam logic [3:0] W6     = 4'd6;
  localparam logic [3:0] W9     = 4'd9;
  localparam logic [3:0] W11    = 4'd11;

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_VALID = 1'b1;

endpackage

// File: rtl/lc3_imm_decode.sv
// rtl/lc3_imm_decode.sv - maps an LC-3 instruction to its sign-extension width code
module lc3_imm_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  imm_width
);

  always_comb begin
    imm_width = W_NONE;
    case (ir[15:12])
      OP_ADD, OP_AND:                        imm_width = ir[5] ? W5 : W_NONE;
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI,
      OP_LEA:                                imm_width = W9;
      OP_JSR:                                imm_width = ir[11] ? W11 : W_NONE;
      OP_LDR, OP_STR:                        imm_width = W6;
      default:                               imm_width = W_NONE;
    endcase
  end

endmodule

// File: rtl/lc3_fetch_unit.sv
// rtl/lc3_fetch_unit.sv - LC-3 PC/IR fetch stage with redirect and decoded immediate outputs
module lc3_fetch_unit
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        dec_ready,
  output logic [15:0] pc_next,
  output logic [11:0] imm_field,
  output logic [3:0]  imm_width
);

  logic [0:0]  state;
  logic [15:0] pc;

  assign mem_req   = (state == S_FETCH);
  assign ir_valid  = (state == S_VALID);
  assign mem_addr  = pc;
  assign imm_field = ir[11:0];

  // A redirect always wins: any returned word is dropped and the target is fetched next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      pc_next <= 16'h0000;
    end else begin
      case (state)
        S_FETCH: begin
          if (pc_load) begin
            pc <= pc_target;
          end else if (mem_rvalid) begin
            ir      <= mem_rdata;
            pc_next <= pc + 16'd1;
            pc      <= pc + 16'd1;
            state   <= S_VALID;
          end
        end
        S_VALID: begin
          if (pc_load) begin
            pc    <= pc_target;
            state <= S_FETCH;
          end else if (dec_ready) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  lc3_imm_decode u_imm_decode (
    .ir        (ir),
    .imm_width (imm_width)
  );

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// tb/tb_lc3_fetch_unit.sv - scoreboard bench for lc3_fetch_unit
module tb_lc3_fetch_unit;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc_next;
    logic [3:0]  width;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] ir;
  logic        ir_valid;
  logic        dec_ready;
  logic [15:0] pc_next;
  logic [11:0] imm_field;
  logic [3:0]  imm_width;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lc3_fetch_unit #(.RESET_PC(16'h3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .dec_ready  (dec_ready),
    .pc_next    (pc_next),
    .imm_field  (imm_field),
    .imm_width  (imm_width)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serves one fetch at addr after `delay` idle request cycles, then checks the captured IR.
  task automatic fetch_word(input logic [15:0] addr, input logic [15:0] data,
                            input int delay, input logic [3:0] width);
    exp_t e;
    exp_t got;
    int t;
    t = 0;
    while (mem_req !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_wait_req: mem_req=%b required 1 within 20 cycles", mem_req);
    end
    for (int i = 0; i <= delay; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || ir_valid !== 1'b0 || mem_addr !== addr) begin
        n_fail++;
        $display("FAIL fetch_req_cycle%0d: mem_req=%b ir_valid=%b mem_addr=%h required 1 0 %h",
                 i, mem_req, ir_valid, mem_addr, addr);
      end
      if (i < delay) step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    e.ir      = data;
    e.pc_next = addr + 16'd1;
    e.width   = width;
    exp_q.push_back(e);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 16'hDEAD;
    n_checks++;
    if (ir_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_capture: ir_valid=%b mem_req=%b required 1 0", ir_valid, mem_req);
    end
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      n_checks++;
      if (ir !== got.ir || pc_next !== got.pc_next || imm_width !== got.width ||
          imm_field !== got.ir[11:0]) begin
        n_fail++;
        $display("FAIL fetch_ir_%h: ir=%h pc_next=%h imm_width=%0d imm_field=%h required %h %h %0d %h",
                 got.ir, ir, pc_next, imm_width, imm_field, got.ir, got.pc_next, got.width,
                 got.ir[11:0]);
      end
    end
  endtask

  task automatic consume();
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL consume: ir_valid=%b mem_req=%b required 0 1", ir_valid, mem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata = 16'h0000;
    pc_load = 1'b0;
    pc_target = 16'h0000;
    dec_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (mem_req !== 1'b1 || ir_valid !== 1'b0 || ir !== 16'h0000 || pc_next !== 16'h0000 ||
        imm_width !== 4'd9 || mem_addr !== 16'h3000) begin
      n_fail++;
      $display("FAIL reset: mem_req=%b ir_valid=%b ir=%h pc_next=%h imm_width=%0d mem_addr=%h required 1 0 0000 0000 9 3000",
               mem_req, ir_valid, ir, pc_next, imm_width, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_min_latency();
    fetch_word(16'h3000, 16'h1261, 0, 4'd5);
    consume();
  endtask

  task automatic test_delayed_and_hold();
    fetch_word(16'h3001, 16'h6042, 3, 4'd6);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (ir !== 16'h6042 || imm_width !== 4'd6 || mem_req !== 1'b0 || ir_valid !== 1'b1 ||
          pc_next !== 16'h3002) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: ir=%h imm_width=%0d mem_req=%b ir_valid=%b pc_next=%h required 6042 6 0 1 3002",
                 i, ir, imm_width, mem_req, ir_valid, pc_next);
      end
    end
    consume();
    n_checks++;
    if (mem_addr !== 16'h3002) begin
      n_fail++;
      $display("FAIL hold_next_addr: mem_addr=%h required 3002", mem_addr);
    end
  endtask

  task automatic test_redirect_in_fetch();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1FFF;
    pc_load    = 1'b1;
    pc_target  = 16'h4000;
    step();
    mem_rvalid = 1'b0;
    pc_load    = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h4000 || ir !== 16'h6042) begin
      n_fail++;
      $display("FAIL redirect_fetch: ir_valid=%b mem_req=%b mem_addr=%h ir=%h required 0 1 4000 6042",
               ir_valid, mem_req, mem_addr, ir);
    end
  endtask

  task automatic test_redirect_in_valid();
    fetch_word(16'h4000, 16'h4800, 0, 4'd11);
    pc_load   = 1'b1;
    pc_target = 16'h4000;
    step();
    pc_load   = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || mem_addr !== 16'h4000 || mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_valid: ir_valid=%b mem_addr=%h mem_req=%b required 0 4000 1",
               ir_valid, mem_addr, mem_req);
    end
    fetch_word(16'h4000, 16'h4000, 1, 4'd0);
    consume();
  endtask

  task automatic test_pc_wrap();
    pc_load   = 1'b1;
    pc_target = 16'hFFFF;
    step();
    pc_load   = 1'b0;
    fetch_word(16'hFFFF, 16'hE1FF, 0, 4'd9);
    n_checks++;
    if (pc_next !== 16'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap: pc_next=%h required 0000", pc_next);
    end
    consume();
    n_checks++;
    if (mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap_addr: mem_addr=%h required 0000", mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    fetch_word(16'h0000, 16'h5042, 0, 4'd0);
    dec_ready = 1'b1;
    pc_load   = 1'b1;
    pc_target = 16'h5000;
    step();
    dec_ready = 1'b0;
    pc_load   = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || mem_addr !== 16'h5000) begin
      n_fail++;
      $display("FAIL redirect_ready: ir_valid=%b mem_addr=%h required 0 5000", ir_valid, mem_addr);
    end
    fetch_word(16'h5000, 16'hF025, 0, 4'd0);
    consume();
    fetch_word(16'h5001, 16'h5062, 2, 4'd5);
    consume();
    fetch_word(16'h5002, 16'h7FC1, 0, 4'd6);
    consume();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_delayed_and_hold();
    test_redirect_in_fetch();
    test_redirect_in_valid();
    test_pc_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_unit.md
Name: lc3_fetch_unit

Overview:
- Front-end stage of the LC-3 datapath: holds the PC and fetches instructions from memory over a valid/ready handshake.
- Latches each fetched word into the instruction register (IR).
- Presents the IR with a decoded immediate field and width code, which feed the sign-extension stage directly (12-bit field, 4-bit width code 0/5/6/9/11).
- Accepts PC redirects from the execute stage; a redirect discards any in-flight fetch.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- mem_req  output  1  fetch request; high for every cycle of the FETCH state
- mem_addr  output  16  fetch address; equals pc
- mem_rdata  input  16  instruction word; valid when mem_rvalid=1
- mem_rvalid  input  1  memory returns data for the mem_addr of the same cycle
- pc_load  input  1  redirect strobe from execute
- pc_target  input  16  redirect target
- ir  output  16  instruction register
- ir_valid  output  1  ir and decoded fields are valid
- dec_ready  input  1  downstream accepts ir this cycle
- pc_next  output  16  address of the instruction after ir (LC-3 incremented PC)
- imm_field  output  12  ir[11:0]
- imm_width  output  4  immediate width code for the sign extender

Behaviour:
- Reset (sync): state=FETCH, pc=RESET_PC, ir=16'h0000, ir_valid=0, pc_next=16'h0000.
  - With ir=0, imm_width=9 (BR opcode), but ir_valid=0.
  - mem_req=1 on the first cycle after reset.
- State FETCH (mem_req=1, mem_addr=pc):
  - mem_rvalid=1 and pc_load=0: ir<=mem_rdata, pc_next<=pc+1, pc<=pc+1 (16-bit wrap, so 16'hFFFF -> 16'h0000), go to VALID.
  - Minimum latency: with mem_rvalid high in the first FETCH cycle, ir_valid rises 1 cycle after mem_req.
  - pc_load=1 (with or without mem_rvalid): pc<=pc_target, returned data is discarded, stay in FETCH.
  - The memory contract permits mem_addr to change while mem_req is high.
- State VALID (ir_valid=1, mem_req=0):
  - dec_ready=1 and pc_load=0: go to FETCH; ir_valid drops next cycle.
  - pc_load=1: pc<=pc_target, ir_valid<=0, go to FETCH. This applies whether or not dec_ready=1, and the consumed/flushed instruction is not refetched.
  - dec_ready=0: ir, pc_next and decoded fields stay stable.
- Priority: rst > pc_load > mem_rvalid / dec_ready.
- Decode is combinational from ir:
  - imm_field = ir[11:0].
  - imm_width by opcode ir[15:12]:
    - 0001 ADD, 0101 AND: ir[5] ? 5 : 0
    - 0000 BR, 0010 LD, 0011 ST, 1010 LDI, 1011 STI, 1110 LEA: 9
    - 0100 JSR: ir[11] ? 11 : 0
    - 0110 LDR, 0111 STR: 6
    - all others (JMP, NOT, RTI, TRAP, reserved): 0

Decomposition:
- Shared package lc3_pkg:
  - opcode constants OP_BR..OP_TRAP.
  - width-code constants W_NONE=0, W5=5, W6=6, W9=9, W11=11.
  - state encoding S_FETCH / S_VALID.
- One natural sub-module, lc3_imm_decode: the combinational ir -> imm_width mapping, reusable by the control unit.

Test Plan:
- Reset, then memory returns 16'h1261 (ADD R1,R1,#1) on the first request -> mem_addr=16'h3000; next cycle ir=16'h1261, ir_valid=1, pc_next=16'h3001, imm_width=5, imm_field=12'h261.
- mem_rvalid delayed 3 cycles -> mem_req high 3 cycles then 1 more; ir_valid=0 throughout; single IR capture.
- Hold dec_ready=0 for 4 cycles with ir=16'h6042 (LDR) -> ir, imm_width=6 stable, mem_req=0; dec_ready=1 -> next cycle mem_addr=16'h3002.
- pc_load=1, pc_target=16'h4000 in the same cycle as mem_rvalid in FETCH -> data discarded, ir_valid stays 0, next mem_addr=16'h4000.
- pc_load=1 in VALID with dec_ready=0 -> ir_valid=0 next cycle, mem_addr=16'h4000; fetch at pc=16'hFFFF -> pc_next=16'h0000.
- Opcode sweep: JSR 16'h4800 -> 11, JSRR 16'h4000 -> 0, LEA 16'hE1FF -> 9, TRAP 16'hF025 -> 0, AND-reg 16'h5042 -> 0.
